fp_align: RTL

//  Pre-add alignment stage of the single-precision FP adder; the counterpart of the post-add left-shift normaliser.

---
 rtl/fp_align.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fp_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fp_align - FP adder pre-add alignment: order operands, shift small, G/S bits |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fp_align #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W-1:0]      exp_out,
  output logic                  sign_big,
  output logic                  eff_sub,
  output logic                  swap,
  output logic [FRAC_W:0]       frac_big,
  output logic [FRAC_W:0]       frac_small,
  output logic                  guard,
  output logic                  sticky,
  output logic                  special
);

  localparam int SIG_W = FRAC_W + 1;
  localparam int W     = EXP_W + FRAC_W + 1;

  // Stage 1: unpack and order by magnitude
  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;
  logic             s1_swap_d;

  assign w_exp_a   = a[W-2 -: EXP_W];
  assign w_exp_b   = b[W-2 -: EXP_W];
  assign w_sig_a   = (w_exp_a == '0) ? '0 : {1'b1, a[FRAC_W-1:0]};
  assign w_sig_b   = (w_exp_b == '0) ? '0 : {1'b1, b[FRAC_W-1:0]};
  assign s1_swap_d = b[W-2:0] > a[W-2:0];

  logic [EXP_W-1:0] s1_exp_big_d, s1_exp_small_d, s1_diff_d;
  logic [SIG_W-1:0] s1_sig_big_d, s1_sig_small_d;

  assign s1_exp_big_d   = s1_swap_d ? w_exp_b : w_exp_a;
  assign s1_exp_small_d = s1_swap_d ? w_exp_a : w_exp_b;
  assign s1_sig_big_d   = s1_swap_d ? w_sig_b : w_sig_a;
  assign s1_sig_small_d = s1_swap_d ? w_sig_a : w_sig_b;
  assign s1_diff_d      = s1_exp_big_d - s1_exp_small_d;

  logic             s1_valid_q, s1_sign_big_q, s1_eff_sub_q, s1_swap_q, s1_special_q;
  logic [EXP_W-1:0] s1_exp_q, s1_diff_q;
  logic [SIG_W-1:0] s1_sig_big_q, s1_sig_small_q;

  // Stage 2: right shift with guard/sticky extraction
  logic [2*SIG_W-1:0] w_ext;
  logic               w_far;
  logic [SIG_W-1:0]   s2_frac_small_d;
  logic               s2_guard_d, s2_sticky_d;

  assign w_ext = {s1_sig_small_q, {SIG_W{1'b0}}} >> s1_diff_q;
  // Beyond SIG_W every bit, including the guard position, has fallen into sticky.
  assign w_far           = s1_diff_q > EXP_W'(SIG_W);
  assign s2_frac_small_d = w_far ? '0   : w_ext[2*SIG_W-1:SIG_W];
  assign s2_guard_d      = w_far ? 1'b0 : w_ext[SIG_W-1];
  assign s2_sticky_d     = w_far ? |s1_sig_small_q : |w_ext[SIG_W-2:0];

  logic             out_valid_q, sign_big_q, eff_sub_q, swap_q, guard_q, sticky_q, special_q;
  logic [EXP_W-1:0] exp_q;
  logic [SIG_W-1:0] frac_big_q, frac_small_q;
  logic             w_s2_load;

  assign w_s2_load = ~out_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | w_s2_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_sign_big_q  <= 1'b0;
      s1_eff_sub_q   <= 1'b0;
      s1_swap_q      <= 1'b0;
      s1_special_q   <= 1'b0;
      s1_exp_q       <= '0;
      s1_diff_q      <= '0;
      s1_sig_big_q   <= '0;
      s1_sig_small_q <= '0;
      out_valid_q    <= 1'b0;
      sign_big_q     <= 1'b0;
      eff_sub_q      <= 1'b0;
      swap_q         <= 1'b0;
      guard_q        <= 1'b0;
      sticky_q       <= 1'b0;
      special_q      <= 1'b0;
      exp_q          <= '0;
      frac_big_q     <= '0;
      frac_small_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_big_q  <= s1_swap_d ? b[W-1] : a[W-1];
          s1_eff_sub_q   <= a[W-1] ^ b[W-1];
          s1_swap_q      <= s1_swap_d;
          s1_special_q   <= (&w_exp_a) | (&w_exp_b);
          s1_exp_q       <= s1_exp_big_d;
          s1_diff_q      <= s1_diff_d;
          s1_sig_big_q   <= s1_sig_big_d;
          s1_sig_small_q <= s1_sig_small_d;
        end
      end
      if (w_s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sign_big_q   <= s1_sign_big_q;
          eff_sub_q    <= s1_eff_sub_q;
          swap_q       <= s1_swap_q;
          special_q    <= s1_special_q;
          exp_q        <= s1_exp_q;
          frac_big_q   <= s1_sig_big_q;
          frac_small_q <= s2_frac_small_d;
          guard_q      <= s2_guard_d;
          sticky_q     <= s2_sticky_d;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign exp_out    = exp_q;
  assign sign_big   = sign_big_q;
  assign eff_sub    = eff_sub_q;
  assign swap       = swap_q;
  assign frac_big   = frac_big_q;
  assign frac_small = frac_small_q;
  assign guard      = guard_q;
  assign sticky     = sticky_q;
  assign special    = special_q;

endmodule
`default_nettype wire
